// File: rtl/tag_lookup.sv
// 8-way tag lookup controller: compares a request tag against an external tag array,
// optionally allocates a way on a miss, and returns hit/way through a ready/valid response.
module tag_lookup (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [23:0]  req_tag,
  input  logic         req_alloc,
  output logic         req_ready,
  input  logic         flush,
  input  logic [191:0] tag_rd,
  output logic [7:0]   we,
  output logic [23:0]  tag_wr,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_hit,
  output logic [2:0]   resp_way
);

  typedef enum logic [1:0] {IDLE, COMPARE, FILL, RESP} state_t;

  state_t      state_reg, state_next;
  logic [23:0] tag_reg, tag_next;
  logic        alloc_reg, alloc_next;
  logic [7:0]  valid_reg, valid_next;
  logic [2:0]  rr_ptr_reg, rr_ptr_next;
  logic [2:0]  victim_reg, victim_next;
  logic        hit_reg, hit_next;
  logic [2:0]  way_reg, way_next;

  logic [7:0]  hit_vec;
  logic        hit_any;
  logic [2:0]  hit_idx;
  logic        inv_any;
  logic [2:0]  inv_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (tag_rd[24*gi +: 24] == tag_reg);
    end
  endgenerate

  // Priority encoders: scanning high-to-low leaves the lowest matching index.
  always_comb begin
    hit_idx = 3'd0;
    inv_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit_vec[i])    hit_idx = 3'(i);
      if (!valid_reg[i]) inv_idx = 3'(i);
    end
    hit_any = |hit_vec;
    inv_any = ~&valid_reg;
  end

  always_comb begin
    state_next  = state_reg;
    tag_next    = tag_reg;
    alloc_next  = alloc_reg;
    valid_next  = valid_reg;
    rr_ptr_next = rr_ptr_reg;
    victim_next = victim_reg;
    hit_next    = hit_reg;
    way_next    = way_reg;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          valid_next = 8'h00;
        end else if (req_valid) begin
          tag_next   = req_tag;
          alloc_next = req_alloc;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (hit_any) begin
          hit_next   = 1'b1;
          way_next   = hit_idx;
          state_next = RESP;
        end else if (!alloc_reg) begin
          hit_next   = 1'b0;
          way_next   = 3'd0;
          state_next = RESP;
        end else begin
          // Free ways are used first; the round-robin pointer only moves when it is consumed.
          if (inv_any) begin
            victim_next = inv_idx;
          end else begin
            victim_next = rr_ptr_reg;
            rr_ptr_next = rr_ptr_reg + 3'd1;
          end
          state_next = FILL;
        end
      end
      FILL: begin
        valid_next[victim_reg] = 1'b1;
        hit_next               = 1'b0;
        way_next               = victim_reg;
        state_next             = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The tag array updates on the falling edge, so this controller does too.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      tag_reg    <= 24'd0;
      alloc_reg  <= 1'b0;
      valid_reg  <= 8'h00;
      rr_ptr_reg <= 3'd0;
      victim_reg <= 3'd0;
      hit_reg    <= 1'b0;
      way_reg    <= 3'd0;
    end else begin
      state_reg  <= state_next;
      tag_reg    <= tag_next;
      alloc_reg  <= alloc_next;
      valid_reg  <= valid_next;
      rr_ptr_reg <= rr_ptr_next;
      victim_reg <= victim_next;
      hit_reg    <= hit_next;
      way_reg    <= way_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign we         = (state_reg == FILL) ? (8'h01 << victim_reg) : 8'h00;
  assign tag_wr     = tag_reg;
  assign resp_hit   = hit_reg;
  assign resp_way   = way_reg;

endmodule

// File: tb/tb_tag_lookup.sv
// Directed bench for tag_lookup with a behavioural 8x24 tag array; the DUT updates on
// the falling edge, so inputs are driven and outputs sampled on the rising edge.
module tb_tag_lookup;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic [23:0]  req_tag;
  logic         req_alloc;
  logic         req_ready;
  logic         flush;
  logic [191:0] tag_rd;
  logic [7:0]   we;
  logic [23:0]  tag_wr;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_hit;
  logic [2:0]   resp_way;

  int checks;
  int errors;

  tag_lookup dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_alloc(req_alloc), .req_ready(req_ready), .flush(flush), .tag_rd(tag_rd),
    .we(we), .tag_wr(tag_wr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array shares the DUT's falling edge and reset.
  logic [23:0] arr [8];
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset)      arr[i] <= 24'd0;
      else if (we[i]) arr[i] <= tag_wr;
    end
  end
  always_comb begin
    tag_rd = '0;
    for (int i = 0; i < 8; i++) tag_rd[24*i +: 24] = arr[i];
  end

  typedef struct {
    logic [23:0] tag;
    logic        alloc;
    logic        hit;
    logic [2:0]  way;
    logic        fill;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check({nm, "_ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input string nm, input logic [23:0] t, input logic a,
                         input logic eh, input logic [2:0] ew, input logic ef);
    wait_ready(nm);
    req_valid = 1'b1;
    req_tag   = t;
    req_alloc = a;
    cyc();
    req_valid = 1'b0;
    check({nm, "_cmp_rv"}, 32'(resp_valid), 32'd0);
    check({nm, "_cmp_rdy"}, 32'(req_ready), 32'd0);
    check({nm, "_cmp_we"}, 32'(we), 32'd0);
    if (ef) begin
      cyc();
      check({nm, "_fill_we"}, 32'(we), 32'(8'h01 << ew));
      check({nm, "_fill_tag"}, 32'(tag_wr), 32'(t));
      check({nm, "_fill_rv"}, 32'(resp_valid), 32'd0);
    end
    cyc();
    check({nm, "_rv"}, 32'(resp_valid), 32'd1);
    check({nm, "_hit"}, 32'(resp_hit), 32'(eh));
    check({nm, "_way"}, 32'(resp_way), 32'(ew));
    check({nm, "_resp_we"}, 32'(we), 32'd0);
    $display("txn %s tag=%06h alloc=%0b hit=%0b way=%0d", nm, t, a, resp_hit, resp_way);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    check({nm, "_done_rv"}, 32'(resp_valid), 32'd0);
    check({nm, "_done_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{24'h00ABCD, 1'b1, 1'b0, 3'd0, 1'b1};
    vecs[1]  = '{24'h00ABCD, 1'b1, 1'b1, 3'd0, 1'b0};
    vecs[2]  = '{24'h000001, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[3]  = '{24'h000002, 1'b1, 1'b0, 3'd2, 1'b1};
    vecs[4]  = '{24'h000003, 1'b1, 1'b0, 3'd3, 1'b1};
    vecs[5]  = '{24'h000004, 1'b1, 1'b0, 3'd4, 1'b1};
    vecs[6]  = '{24'h000005, 1'b1, 1'b0, 3'd5, 1'b1};
    vecs[7]  = '{24'h000006, 1'b1, 1'b0, 3'd6, 1'b1};
    vecs[8]  = '{24'h000007, 1'b1, 1'b0, 3'd7, 1'b1};
    vecs[9]  = '{24'h100000, 1'b1, 1'b0, 3'd0, 1'b1};
    vecs[10] = '{24'h200000, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[11] = '{24'h100000, 1'b1, 1'b1, 3'd0, 1'b0};
    vecs[12] = '{24'h00ABCD, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{24'h000002, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[14] = '{24'h200000, 1'b1, 1'b1, 3'd1, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_tag = 24'd0; req_alloc = 1'b0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    cyc();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_tag_wr", 32'(tag_wr), 32'd0);
    check("rst_hit", 32'(resp_hit), 32'd0);
    check("rst_way", 32'(resp_way), 32'd0);

    for (int i = 0; i < 15; i++)
      run_req($sformatf("v%0d", i), vecs[i].tag, vecs[i].alloc, vecs[i].hit,
              vecs[i].way, vecs[i].fill);

    // Non-allocating miss held under backpressure.
    wait_ready("bp");
    req_valid = 1'b1; req_tag = 24'h0ABCDE; req_alloc = 1'b0;
    cyc();
    req_valid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_rv", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_hit", k), 32'(resp_hit), 32'd0);
      check($sformatf("bp%0d_way", k), 32'(resp_way), 32'd0);
      check($sformatf("bp%0d_rdy", k), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d_we", k), 32'(we), 32'd0);
      cyc();
    end
    $display("txn bp tag=0abcde alloc=0 hit=%0b way=%0d held 3 cycles", resp_hit, resp_way);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    check("bp_done_rv", 32'(resp_valid), 32'd0);

    // Flush wins over a simultaneous request.
    wait_ready("fl");
    flush = 1'b1; req_valid = 1'b1; req_tag = 24'h000003; req_alloc = 1'b1;
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    check("fl_rdy0", 32'(req_ready), 32'd1);
    check("fl_rv0", 32'(resp_valid), 32'd0);
    cyc();
    check("fl_rdy1", 32'(req_ready), 32'd1);
    check("fl_we", 32'(we), 32'd0);
    $display("txn flush with req_valid: request dropped");
    run_req("fl_miss", 24'h000003, 1'b0, 1'b0, 3'd0, 1'b0);
    run_req("fl_fill", 24'h000005, 1'b1, 1'b0, 3'd0, 1'b1);

    // Reset asserted while FILL is driving the array.
    wait_ready("rf");
    req_valid = 1'b1; req_tag = 24'h777777; req_alloc = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("rf_fill_we", 32'(we), 32'h02);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rf_we", 32'(we), 32'd0);
    check("rf_rdy", 32'(req_ready), 32'd1);
    check("rf_rv", 32'(resp_valid), 32'd0);
    check("rf_tag_wr", 32'(tag_wr), 32'd0);
    check("rf_way", 32'(resp_way), 32'd0);
    $display("txn reset during fill");
    run_req("rf_miss0", 24'h000005, 1'b0, 1'b0, 3'd0, 1'b0);
    run_req("rf_miss1", 24'h777777, 1'b0, 1'b0, 3'd0, 1'b0);
    run_req("rf_fill", 24'hABCDEF, 1'b1, 1'b0, 3'd0, 1'b1);
    run_req("rf_hit", 24'hABCDEF, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_lookup.md
TAG_LOOKUP -- requirements
Module: tag_lookup

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on the falling edge of clk, matching the tag array.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the falling edge of clk.
REQ-003 SHALL have port: req_valid  input  1  lookup request strobe.
REQ-004 SHALL have port: req_tag  input  24  tag to look up.
REQ-005 SHALL have port: req_alloc  input  1  allocate a way on a miss; sampled with req_tag.
REQ-006 SHALL have port: req_ready  output  1  block can accept a request.
REQ-007 SHALL have port: flush  input  1  invalidate all 8 ways.
REQ-008 SHALL have port: tag_rd  input  192  tag array outputs; way i occupies bits [24i+23:24i].
REQ-009 SHALL have port: we  output  8  one-hot write enable to the tag array.
REQ-010 SHALL have port: tag_wr  output  24  write data to the tag array.
REQ-011 SHALL have port: resp_valid  output  1  response available.
REQ-012 SHALL have port: resp_ready  input  1  response consumed.
REQ-013 SHALL have port: resp_hit  output  1  1 = hit, 0 = miss.
REQ-014 SHALL have port: resp_way  output  3  way that hit or was allocated.

Function
REQ-015 SHALL implement FSM states IDLE, COMPARE, FILL and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, flush=1 SHALL clear all 8 internal valid bits at that edge and stay in IDLE; flush takes priority over req_valid.
REQ-017 In IDLE with req_valid=1 and flush=0, the block SHALL latch req_tag and req_alloc, then go to COMPARE.
REQ-018 flush SHALL be ignored outside IDLE.
REQ-019 COMPARE hit condition: way i hits when valid[i]=1 and tag_rd way i equals the latched tag.
REQ-020 On a hit in COMPARE: resp_hit=1, resp_way = lowest-index hitting way, next state RESP.
REQ-021 On a miss with req_alloc=0: resp_hit=0, resp_way=0, next state RESP; no write.
REQ-022 On a miss with req_alloc=1, the victim SHALL be the lowest-index invalid way if any exists; otherwise the victim is the round-robin pointer rr_ptr. Next state FILL.
REQ-023 In FILL, the block SHALL for exactly one cycle drive we = one-hot(victim) and tag_wr = latched tag.
REQ-024 At the end of FILL, the block SHALL set valid[victim]=1; resp_hit=0; resp_way=victim; next state RESP.
REQ-025 rr_ptr (3 bits) SHALL increment only when the victim was taken from rr_ptr, and SHALL wrap 7 to 0.
REQ-026 Outside FILL, we SHALL be 0.
REQ-027 tag_wr SHALL hold the latched tag at all times.
REQ-028 In RESP, resp_valid=1 and resp_hit/resp_way SHALL be held stable until resp_ready=1 is sampled; the block then returns to IDLE.
REQ-029 resp_valid SHALL be 0 in all states other than RESP.
REQ-030 Latency: a request accepted at edge N SHALL give resp_valid=1 after edge N+1 on a hit or non-allocating miss, and after edge N+2 on an allocating miss.
REQ-031 Back-to-back operation: after RESP completes, one IDLE cycle SHALL precede the next acceptance.

Reset
REQ-032 reset=1 SHALL, at the next falling edge and in any state (including mid-FILL), force state=IDLE, valid=0, rr_ptr=0, we=0, resp_valid=0, resp_hit=0, resp_way=0, tag_wr=0.
REQ-033 Any pending request or response SHALL be discarded on reset.
REQ-034 reset SHALL take priority over flush and req_valid.
REQ-035 The tag array SHALL be driven from the same reset.

Verification
REQ-036 Scenario, cold miss: after reset, req_tag=24'h00ABCD with req_alloc=1 -> we=8'h01 for one cycle, tag_wr=24'h00ABCD; response resp_hit=0, resp_way=0.
REQ-037 Scenario, hit after fill: repeat 24'h00ABCD -> resp_hit=1, resp_way=0; no we pulse.
REQ-038 Scenario, fill and wrap: fill 8 distinct tags (ways 0-7 in order), then a 9th miss -> victim way 0 (rr_ptr=0 to 1); a 10th miss -> victim way 1.
REQ-039 Scenario, non-allocating miss and backpressure: req_alloc=0 miss with resp_ready=0 for 3 cycles -> resp_valid held with resp_hit=0, resp_way=0, req_ready=0, no write.
REQ-040 Scenario, flush priority: flush=1 together with req_valid=1 in IDLE -> all valid bits cleared, request not accepted; a subsequent lookup of a previously filled tag -> miss.
REQ-041 Scenario, reset mid-FILL: assert reset in FILL -> we=0 at the next edge, state IDLE, and all later lookups miss.
